// File: rtl/paddle_controller.sv
// Per-frame paddle position generator: synchronizes the player buttons and moves the
// paddle centre once per qualified frame tick with a hold-to-accelerate speed profile.
module paddle_controller #(
   parameter int unsigned SCREEN_WIDTH = 640,
   parameter int unsigned PADDLE_WIDTH = 99,
   parameter int unsigned X_RESET      = 320,
   parameter int unsigned SPEED_MIN    = 2,
   parameter int unsigned SPEED_MAX    = 8,
   parameter int unsigned ACCEL_FRAMES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       enable,
   input  logic       btn_left,
   input  logic       btn_right,
   output logic [9:0] x,
   output logic       moving
);

   localparam int unsigned SpeedW = $clog2(SPEED_MAX + 1);
   localparam int unsigned CntW   = $clog2(ACCEL_FRAMES + 1);

   localparam logic [9:0]        XMin    = 10'(PADDLE_WIDTH / 2);
   localparam logic [9:0]        XMax    = 10'(SCREEN_WIDTH - (PADDLE_WIDTH + 1) / 2);
   localparam logic [9:0]        XRst    = 10'(X_RESET);
   localparam logic [SpeedW-1:0] SpdMin  = SpeedW'(SPEED_MIN);
   localparam logic [SpeedW-1:0] SpdMax  = SpeedW'(SPEED_MAX);
   localparam logic [CntW-1:0]   CntWrap = CntW'(ACCEL_FRAMES);

   typedef enum logic [1:0] {StIdle, StMoveL, StMoveR} state_e;

   logic bl_meta, bl_s, br_meta, br_s;

   state_e            state_q, state_d;
   logic [SpeedW-1:0] speed_q, speed_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [9:0]        x_q, x_d;
   logic              moving_q, moving_d;

   logic              go_left, go_right, same_dir, clamp_l, clamp_r, clamped;
   state_e            tgt_state;
   logic [SpeedW-1:0] cur_speed;
   logic [CntW-1:0]   cur_cnt, cnt_inc;
   logic [10:0]       x_ext, spd_ext, lo_bound, hi_sum;
   logic [9:0]        x_move;

   // Two-flop synchronizers; the raw buttons are asynchronous to clk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bl_meta <= 1'b0;
         bl_s    <= 1'b0;
         br_meta <= 1'b0;
         br_s    <= 1'b0;
      end else begin
         bl_meta <= btn_left;
         bl_s    <= bl_meta;
         br_meta <= btn_right;
         br_s    <= br_meta;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         speed_q  <= SpdMin;
         cnt_q    <= '0;
         x_q      <= XRst;
         moving_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         speed_q  <= speed_d;
         cnt_q    <= cnt_d;
         x_q      <= x_d;
         moving_q <= moving_d;
      end
   end

   assign go_left   = bl_s & ~br_s;
   assign go_right  = br_s & ~bl_s;
   assign tgt_state = go_left ? StMoveL : StMoveR;
   assign same_dir  = (state_q == tgt_state);

   // A fresh direction restarts the profile; the entry frame itself counts as one frame.
   assign cur_speed = same_dir ? speed_q : SpdMin;
   assign cur_cnt   = same_dir ? cnt_q : '0;
   assign cnt_inc   = cur_cnt + 1'b1;

   // 11-bit intermediates keep the bound checks free of wrap-around.
   assign x_ext    = {1'b0, x_q};
   assign spd_ext  = 11'(cur_speed);
   assign lo_bound = {1'b0, XMin} + spd_ext;
   assign hi_sum   = x_ext + spd_ext;
   assign clamp_l  = (x_ext < lo_bound);
   assign clamp_r  = (hi_sum > {1'b0, XMax});
   assign clamped  = go_left ? clamp_l : clamp_r;

   always_comb begin
      x_move = x_q;
      if (go_left) begin
         x_move = clamp_l ? XMin : (x_q - 10'(cur_speed));
      end else begin
         x_move = clamp_r ? XMax : hi_sum[9:0];
      end
   end

   always_comb begin
      state_d  = state_q;
      speed_d  = speed_q;
      cnt_d    = cnt_q;
      x_d      = x_q;
      moving_d = moving_q;
      if (frame_tick && enable) begin
         if (go_left || go_right) begin
            state_d  = tgt_state;
            x_d      = x_move;
            moving_d = (x_move != x_q);
            if (clamped) begin
               speed_d = SpdMin;
               cnt_d   = '0;
            end else if (cnt_inc == CntWrap) begin
               cnt_d   = '0;
               speed_d = (cur_speed >= SpdMax) ? SpdMax : cur_speed + 1'b1;
            end else begin
               cnt_d   = cnt_inc;
               speed_d = cur_speed;
            end
         end else begin
            state_d  = StIdle;
            speed_d  = SpdMin;
            cnt_d    = '0;
            moving_d = 1'b0;
         end
      end
   end

   assign x      = x_q;
   assign moving = moving_q;

endmodule

// File: tb/tb_paddle_controller.sv
// Bench for paddle_controller: fixed vector table, hand-written wall/reset sequences and
// random button traffic checked against an integer model of the movement rules.
module tb_paddle_controller;

   localparam int XMIN = 49;
   localparam int XMAX = 590;

   logic       clk;
   logic       rst;
   logic       frame_tick;
   logic       enable;
   logic       btn_left;
   logic       btn_right;
   logic [9:0] x;
   logic       moving;

   paddle_controller dut (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .enable     (enable),
      .btn_left   (btn_left),
      .btn_right  (btn_right),
      .x          (x),
      .moving     (moving)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: position, last direction (-1/0/+1), speed and frames at that speed.
   int m_x, m_dir, m_spd, m_run;
   bit m_mv;

   typedef struct {
      bit do_rst;
      bit l;
      bit r;
      bit en;
      int exp_x;
      bit exp_mv;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(bit rs, bit l, bit r, bit en, int ex, bit em);
      vec_t v;
      v.do_rst = rs;
      v.l      = l;
      v.r      = r;
      v.en     = en;
      v.exp_x  = ex;
      v.exp_mv = em;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_x   = 320;
      m_dir = 0;
      m_spd = 2;
      m_run = 0;
      m_mv  = 1'b0;
   endtask

   task automatic model_step(input bit l, input bit r, input bit en);
      int d, nx;
      bit hit;
      if (!en) return;
      if (l == r) begin
         m_dir = 0;
         m_spd = 2;
         m_run = 0;
         m_mv  = 1'b0;
         return;
      end
      d = l ? -1 : 1;
      if (d != m_dir) begin
         m_spd = 2;
         m_run = 0;
      end
      m_dir = d;
      nx  = m_x + d * m_spd;
      hit = 1'b0;
      if (nx < XMIN) begin nx = XMIN; hit = 1'b1; end
      if (nx > XMAX) begin nx = XMAX; hit = 1'b1; end
      m_mv = (nx != m_x);
      m_x  = nx;
      if (hit) begin
         m_spd = 2;
         m_run = 0;
      end else begin
         m_run++;
         if (m_run == 4) begin
            m_run = 0;
            if (m_spd < 8) m_spd++;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst        = 1'b1;
      btn_left   = 1'b0;
      btn_right  = 1'b0;
      frame_tick = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // Buttons settle for 3 cycles before the tick so the synchronizers see them.
   task automatic do_tick(input bit l, input bit r, input bit en, input int n_ticks);
      @(negedge clk);
      btn_left  = l;
      btn_right = r;
      enable    = en;
      repeat (3) @(negedge clk);
      frame_tick = 1'b1;
      repeat (n_ticks) begin
         @(negedge clk);
         model_step(l, r, en);
      end
      frame_tick = 1'b0;
   endtask

   task automatic check_model(input string tag);
      check({tag, "_x"}, int'(x), m_x);
      check({tag, "_mv"}, int'(moving), int'(m_mv));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int seq_a[9] = '{322, 324, 326, 328, 331, 334, 337, 340, 344};
      int seq_b[5] = '{322, 324, 326, 328, 331};
      int seq_l[6] = '{58, 56, 54, 52, 49, 49};
      bit rl, rr, ren;

      rst        = 1'b1;
      frame_tick = 1'b0;
      enable     = 1'b1;
      btn_left   = 1'b0;
      btn_right  = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset_x", int'(x), 320);
      check("reset_mv", int'(moving), 0);
      rst = 1'b0;

      // Idle after reset, then right-hold acceleration.
      add(1, 0, 0, 1, 320, 0);
      add(0, 0, 0, 1, 320, 0);
      add(0, 0, 0, 1, 320, 0);
      foreach (seq_a[k]) add(0, 0, 1, 1, seq_a[k], 1);
      // Direction reversal restarts at minimum speed; both buttons stop.
      add(1, 0, 1, 1, seq_b[0], 1);
      for (int k = 1; k < 5; k++) add(0, 0, 1, 1, seq_b[k], 1);
      add(0, 1, 0, 1, 329, 1);
      add(0, 1, 1, 1, 329, 0);
      // Disabled ticks are ignored.
      add(1, 0, 1, 0, 320, 0);
      for (int k = 0; k < 3; k++) add(0, 0, 1, 0, 320, 0);
      add(0, 0, 1, 1, 322, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].do_rst) do_reset();
         do_tick(vecs[i].l, vecs[i].r, vecs[i].en, 1);
         check($sformatf("vec%0d_x", i), int'(x), vecs[i].exp_x);
         check($sformatf("vec%0d_mv", i), int'(moving), int'(vecs[i].exp_mv));
      end

      // Left wall, climb back to 60, then left approach ending clamped at 49.
      do_reset();
      for (int k = 0; k < 60; k++) begin
         do_tick(1, 0, 1, 1);
         check_model($sformatf("lwall%0d", k));
      end
      check("lwall_x", int'(x), XMIN);
      check("lwall_mv", int'(moving), 0);
      for (int k = 0; k < 5; k++) do_tick(0, 1, 1, 1);
      check("climb_x", int'(x), 60);
      foreach (seq_l[k]) begin
         do_tick(1, 0, 1, 1);
         check($sformatf("lapp%0d_x", k), int'(x), seq_l[k]);
      end
      check("lapp_last_mv", int'(moving), 0);
      do_tick(1, 0, 1, 1);
      check("lspd_reset_x", int'(x), XMIN);
      do_tick(0, 1, 1, 1);
      check("after_wall_x", int'(x), 51);

      // Right wall.
      for (int k = 0; k < 90; k++) begin
         do_tick(0, 1, 1, 1);
         check_model($sformatf("rwall%0d", k));
      end
      check("rwall_x", int'(x), XMAX);
      check("rwall_mv", int'(moving), 0);

      // Back-to-back tick cycles count as two updates.
      do_reset();
      do_tick(0, 1, 1, 2);
      check("dbl_x", int'(x), 324);
      check_model("dbl");

      // Reset asserted mid-hold returns immediately; next tick moves at minimum speed.
      do_reset();
      for (int k = 0; k < 6; k++) do_tick(0, 1, 1, 1);
      check("prehold_x", int'(x), 334);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_x", int'(x), 320);
      check("midrst_mv", int'(moving), 0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      do_tick(0, 1, 1, 1);
      check("postrst_x", int'(x), 322);
      check("postrst_mv", int'(moving), 1);

      // Random traffic with held patterns and occasional pauses.
      rl = 1'b0;
      rr = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 4) == 0) begin
            rl = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 1));
         end
         ren = ($urandom_range(0, 9) != 0);
         do_tick(rl, rr, ren, ($urandom_range(0, 19) == 0) ? 2 : 1);
         check_model($sformatf("rnd%0d", k));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/paddle_controller.md
# paddle_controller

Per-frame paddle position generator. Samples the left/right player buttons, applies a simple hold-to-accelerate speed profile, and updates the paddle centre coordinate `x` once per video frame, clamped so the paddle never leaves the visible area. Sits directly upstream of the paddle painter, which consumes `x`. The ball/collision logic also consumes `x`.

## Interface
- `SCREEN_WIDTH`, 640: visible pixels per line.
- `PADDLE_WIDTH`, 99: paddle width in pixels; must be odd and match the painter.
- `X_RESET`, 320: centre position after reset.
- `SPEED_MIN`, 2: pixels/frame on first move.
- `SPEED_MAX`, 8: speed ceiling, pixels/frame.
- `ACCEL_FRAMES`, 4: frames moved at one speed before speed increments.

Ports:
- `clk` in 1: pixel clock, single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `frame_tick` in 1: one-cycle pulse at the start of vertical blanking.
- `enable` in 1: 0 freezes the paddle, e.g. on pause or game over.
- `btn_left` in 1: raw button input, asynchronous, active-high.
- `btn_right` in 1: raw button input, asynchronous, active-high.
- `x` out 10: registered paddle centre pixel column.
- `moving` out 1: registered; 1 if `x` changed on the last frame update.

## Operation
- Button inputs pass through a 2-flop synchronizer each (`bl_s`, `br_s`). Only synchronized values are used.
- Clamp bounds:
  - XMIN = PADDLE_WIDTH/2 = 49.
  - XMAX = SCREEN_WIDTH − (PADDLE_WIDTH+1)/2 = 590.
  - At XMAX the painter's rightmost pixel is 639.
- State machine with states IDLE, MOVE_L and MOVE_R. It is evaluated only in cycles where `frame_tick`=1 and `enable`=1.
  - Exactly `bl_s`: go to MOVE_L.
  - Exactly `br_s`: go to MOVE_R.
  - Neither or both pressed: go to IDLE. `x` is unchanged, speed is set to SPEED_MIN and the accel counter to 0.
  - Entering MOVE_L/MOVE_R from IDLE or from the opposite direction: speed is set to SPEED_MIN and the accel counter to 0, then the move is applied at SPEED_MIN.
  - Staying in the same direction: apply the move at the current speed, then increment the accel counter. When the counter reaches ACCEL_FRAMES, it wraps to 0 and speed increments, saturating at SPEED_MAX.
- Move arithmetic uses 11-bit intermediates, so no wrap-around is possible.
  - Left: if x < XMIN + speed, x ← XMIN; otherwise x ← x − speed.
  - Right: if x + speed > XMAX, x ← XMAX; otherwise x ← x + speed.
- Clamping: when a move is clamped, speed resets to SPEED_MIN and the counter to 0. The state stays MOVE_L/MOVE_R.
- Holding against a wall leaves `x` at the bound with `moving`=0.
- `enable`=0: `frame_tick` is ignored. `x`, speed, counter and state all hold. Synchronizers keep running.
- `moving` is updated on every qualified tick: 1 iff the new `x` ≠ old `x`. It holds between ticks.

## Timing
- Reset values: `x`=X_RESET (320), `moving`=0, state IDLE, speed SPEED_MIN, counter 0, synchronizer flops 0.
- Button-to-sample latency is 2 clk cycles. A press must be stable ≥2 cycles before `frame_tick` to count.
- `x` and `moving` change on the clk edge at the end of the `frame_tick` cycle. They are stable for the whole following frame, including active video.
- `frame_tick` asserted on consecutive cycles: each cycle is a separate update. Legal but not expected.
- Reset mid-hold: immediate return to reset values. After release, the first qualified tick with a button held moves at SPEED_MIN.

## Test plan
- Reset, 3 ticks with no buttons → `x`=320, `moving`=0 throughout.
- Hold right for 9 ticks → `x` sequence 322, 324, 326, 328, 331, 334, 337, 340, 344, with `moving`=1.
- Starting at `x`=60, hold left → `x` sequence 58, 56, 54, 52, 49, 49, with `moving`=0 on the last tick and speed back at 2. Mirror test at the right edge ends at `x`=590.
- Hold right for 5 ticks (`x`=331), then switch to left → `x`=329 (speed reset). Then hold both → `x`=329, `moving`=0.
- Hold right with `enable`=0 for 4 ticks → `x`=320 unchanged. Raise `enable` → next tick `x`=322.
- Hold right for 6 ticks, assert `rst` mid-frame → `x`=320 immediately. Release `rst` → next tick `x`=322.
